// File: rtl/halt_pkg.sv
// halt_pkg: shared types and constants for the simulation-halt controller.
//   halt_state_e      - controller FSM state encoding
//   EBREAK_INST       - RV32 ebreak encoding watched on the retire stream
//   HALT_CODE_TIMEOUT - halt_code reported when the watchdog fires
package halt_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } halt_state_e;

  localparam logic [31:0] EBREAK_INST       = 32'h0010_0073;
  localparam logic [31:0] HALT_CODE_TIMEOUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_wdog.sv
// halt_wdog: free-running cycle watchdog for the halt controller.
// Only instantiated when HALT_WDOG_EN is defined.
// Ports:
//   clk     - clock, rising edge
//   clr     - synchronous clear of the cycle counter
//   en      - count enable (controller is in RUN)
//   expired - counter has reached LIMIT-1 while enabled
module halt_wdog #(
  parameter logic [31:0] LIMIT = 32'd1000000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] cnt;

  assign expired = en && (cnt == LIMIT - 32'd1);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// halt_ctrl: hardware end of the simulation-halt protocol.
// Detects ebreak on the retire stream, stalls the core, waits DRAIN_CYCLES
// for in-flight writes, samples $a0 and offers one halt report over a
// valid/ready handshake.
//
// Optional feature: define HALT_WDOG_EN to add a cycle watchdog that forces
// a report (timeout=1, halt_code=FFFF_FFFF) after TIMEOUT cycles in RUN.
//
// State table:
//   state  | meaning
//   RUN    | counting retires, watching for ebreak
//   DRAIN  | stalled, waiting for in-flight writes before sampling $a0
//   REPORT | stalled, halt report offered (halt_valid=1)
//   DONE   | report accepted, stalled until reset
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   inst_valid/inst/pc  - retire stream
//   gpr10               - architectural $a0
//   stall               - freeze fetch/retire
//   halt_valid/ready    - report handshake
//   halt_pc/code/good   - report payload
//   timeout             - report caused by watchdog
//   icount              - instructions retired in RUN (including the ebreak)
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] TIMEOUT      = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] gpr10,
  output logic        stall,
  output logic        halt_valid,
  input  logic        halt_ready,
  output logic [31:0] halt_pc,
  output logic [31:0] halt_code,
  output logic        halt_good,
  output logic        timeout,
  output logic [63:0] icount
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  halt_state_e state, state_nxt;
  logic [3:0]  drain_cnt;
  logic [31:0] last_pc;
  logic        is_ebreak;
  logic        wdog_expired;

  assign is_ebreak = inst_valid && (inst == EBREAK_INST);

`ifdef HALT_WDOG_EN
  halt_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .clr    (rst),
    .en     (state == ST_RUN),
    .expired(wdog_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        // ebreak has priority over a watchdog expiring in the same cycle
        if (is_ebreak) begin
          state_nxt = ST_DRAIN;
        end else if (wdog_expired) begin
          state_nxt = ST_REPORT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (halt_ready) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_DONE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    halt_valid = 1'b0;
    case (state)
      ST_RUN:    ;
      ST_DRAIN:  stall = 1'b1;
      ST_REPORT: begin
        stall      = 1'b1;
        halt_valid = 1'b1;
      end
      default:   stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
      last_pc   <= '0;
      halt_pc   <= '0;
      halt_code <= '0;
      timeout   <= 1'b0;
      icount    <= '0;
    end else begin
      if (inst_valid) begin
        last_pc <= pc;
      end
      case (state)
        ST_RUN: begin
          if (inst_valid) begin
            icount <= icount + 64'd1;
          end
          if (is_ebreak) begin
            halt_pc   <= pc;
            drain_cnt <= DRAIN_LOAD;
          end else if (wdog_expired) begin
            // a retire in the expiry cycle is the most recent one
            halt_pc   <= inst_valid ? pc : last_pc;
            halt_code <= HALT_CODE_TIMEOUT;
            timeout   <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            halt_code <= gpr10;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign halt_good = (halt_code == 32'd0);

endmodule

// File: tb/tb_halt_ctrl.sv
module tb_halt_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] gpr10;
  logic        stall;
  logic        halt_valid;
  logic        halt_ready;
  logic [31:0] halt_pc;
  logic [31:0] halt_code;
  logic        halt_good;
  logic        timeout;
  logic [63:0] icount;

  int checks;
  int failures;

  halt_ctrl #(
    .DRAIN_CYCLES(2),
    .TIMEOUT     (32'd20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_valid(inst_valid),
    .inst      (inst),
    .pc        (pc),
    .gpr10     (gpr10),
    .stall     (stall),
    .halt_valid(halt_valid),
    .halt_ready(halt_ready),
    .halt_pc   (halt_pc),
    .halt_code (halt_code),
    .halt_good (halt_good),
    .timeout   (timeout),
    .icount    (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".stall"},      64'(stall),      64'd0);
    chk({tag, ".halt_valid"}, 64'(halt_valid), 64'd0);
    chk({tag, ".timeout"},    64'(timeout),    64'd0);
    chk({tag, ".halt_good"},  64'(halt_good),  64'd1);
    chk({tag, ".halt_pc"},    64'(halt_pc),    64'd0);
    chk({tag, ".halt_code"},  64'(halt_code),  64'd0);
    chk({tag, ".icount"},     icount,          64'd0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = NOP;
    pc         = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic retire(input logic [31:0] i, input logic [31:0] p);
    inst_valid = 1'b1;
    inst       = i;
    pc         = p;
    tick();
    inst_valid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    gpr10      = 32'd0;
    halt_ready = 1'b0;
    do_reset();
    chk_reset_values("reset");

    // normal halt: three instructions then ebreak, ready already high
    halt_ready = 1'b1;
    gpr10      = 32'd0;
    retire(NOP, 32'h8000_0000);
    retire(NOP, 32'h8000_0004);
    retire(NOP, 32'h8000_0008);
    chk("run.icount3", icount, 64'd3);
    chk("run.nostall", 64'(stall), 64'd0);
    inst_valid = 1'b1; inst = EBREAK; pc = 32'h8000_000C;
    tick();
    // one extra retire in T+1 must be ignored
    inst = NOP; pc = 32'h8000_0010;
    chk("drain1.stall",  64'(stall),      64'd1);
    chk("drain1.valid",  64'(halt_valid), 64'd0);
    chk("drain1.icount", icount,          64'd4);
    tick();
    inst_valid = 1'b0;
    chk("drain2.valid",  64'(halt_valid), 64'd0);
    chk("drain2.icount", icount,          64'd4);
    tick();
    chk("rep.valid",  64'(halt_valid), 64'd1);
    chk("rep.pc",     64'(halt_pc),    64'h8000_000C);
    chk("rep.code",   64'(halt_code),  64'd0);
    chk("rep.good",   64'(halt_good),  64'd1);
    chk("rep.icount", icount,          64'd4);
    chk("rep.tmo",    64'(timeout),    64'd0);
    tick();
    chk("done.valid", 64'(halt_valid), 64'd0);
    chk("done.stall", 64'(stall),      64'd1);
    tick();
    tick();
    chk("done2.valid", 64'(halt_valid), 64'd0);
    chk("done2.stall", 64'(stall),      64'd1);

    // ecall: counted, no halt
    do_reset();
    gpr10 = 32'd0;
    retire(ECALL, 32'h8000_0100);
    chk("ecall.stall",  64'(stall),      64'd0);
    chk("ecall.valid",  64'(halt_valid), 64'd0);
    chk("ecall.icount", icount,          64'd1);
    tick();
    tick();
    tick();
    chk("ecall.stall3", 64'(stall),      64'd0);
    chk("ecall.valid3", 64'(halt_valid), 64'd0);

    // gpr10 changes during drain; ready held low for 10 cycles
    do_reset();
    halt_ready = 1'b0;
    retire(NOP, 32'h8000_0200);
    gpr10 = 32'd5;
    retire(EBREAK, 32'h8000_0204);
    tick();
    gpr10 = 32'd1;
    tick();
    gpr10 = 32'd7;
    chk("bad.valid", 64'(halt_valid), 64'd1);
    chk("bad.code",  64'(halt_code),  64'd1);
    chk("bad.good",  64'(halt_good),  64'd0);
    for (int c = 0; c < 9; c++) begin
      tick();
      chk("hold.valid",  64'(halt_valid), 64'd1);
      chk("hold.pc",     64'(halt_pc),    64'h8000_0204);
      chk("hold.code",   64'(halt_code),  64'd1);
      chk("hold.icount", icount,          64'd2);
    end
    halt_ready = 1'b1;
    tick();
    chk("hs.valid", 64'(halt_valid), 64'd0);
    chk("hs.stall", 64'(stall),      64'd1);

    // reset during DRAIN, then during REPORT, then a normal halt
    do_reset();
    halt_ready = 1'b0;
    retire(EBREAK, 32'h8000_0300);
    chk("rd.stall", 64'(stall), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("rst_drain");
    gpr10 = 32'd9;
    retire(EBREAK, 32'h8000_0400);
    tick();
    tick();
    chk("rr.valid", 64'(halt_valid), 64'd1);
    chk("rr.code",  64'(halt_code),  64'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("rst_report");
    gpr10      = 32'd3;
    halt_ready = 1'b1;
    retire(NOP, 32'h8000_0500);
    retire(EBREAK, 32'h8000_0504);
    tick();
    tick();
    chk("after.valid",  64'(halt_valid), 64'd1);
    chk("after.pc",     64'(halt_pc),    64'h8000_0504);
    chk("after.code",   64'(halt_code),  64'd3);
    chk("after.icount", icount,          64'd2);
    tick();
    chk("after.done", 64'(halt_valid), 64'd0);

`ifdef HALT_WDOG_EN
    // watchdog: TIMEOUT=20, no ebreak -> report at cycle 20
    do_reset();
    halt_ready = 1'b0;
    gpr10      = 32'd0;
    retire(NOP, 32'h0000_0100);
    retire(NOP, 32'h0000_0104);
    for (int c = 2; c < 19; c++) tick();
    chk("wd.pre.valid", 64'(halt_valid), 64'd0);
    chk("wd.pre.stall", 64'(stall),      64'd0);
    tick();
    chk("wd.valid",  64'(halt_valid), 64'd1);
    chk("wd.tmo",    64'(timeout),    64'd1);
    chk("wd.code",   64'(halt_code),  64'hFFFF_FFFF);
    chk("wd.good",   64'(halt_good),  64'd0);
    chk("wd.pc",     64'(halt_pc),    64'h0000_0104);
    chk("wd.icount", icount,          64'd2);

    // ebreak exactly on the limit cycle wins
    do_reset();
    gpr10 = 32'd4;
    for (int c = 0; c < 19; c++) tick();
    retire(EBREAK, 32'h0000_0200);
    chk("wde.stall", 64'(stall),      64'd1);
    chk("wde.valid", 64'(halt_valid), 64'd0);
    tick();
    tick();
    chk("wde.rvalid", 64'(halt_valid), 64'd1);
    chk("wde.tmo",    64'(timeout),    64'd0);
    chk("wde.code",   64'(halt_code),  64'd4);
    chk("wde.pc",     64'(halt_pc),    64'h0000_0200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
